alu_share_ctrl: RTL

ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

---
 rtl/alu_share_ctrl_if.sv | 44 ++++
 rtl/alu_share_ctrl.sv | 102 ++++++++++
 2 files changed

// File: rtl/alu_share_ctrl_if.sv
// Bundle between two requesters, the shared combinational ALU and the response consumer.
// slave is the arbiter's view; master is the surrounding system's view.
interface alu_share_ctrl_if;
    logic       req0_valid;
    logic       req1_valid;
    logic [7:0] req0_inst;
    logic [7:0] req1_inst;
    logic [7:0] req0_ra;
    logic [7:0] req0_rb;
    logic [7:0] req1_ra;
    logic [7:0] req1_rb;
    logic       req0_ready;
    logic       req1_ready;
    logic [7:0] alu_inst;
    logic [7:0] alu_ra;
    logic [7:0] alu_rb;
    logic [7:0] alu_rd;
    logic [7:0] alu_flags;
    logic       rsp_valid;
    logic       rsp_id;
    logic [7:0] rsp_rd;
    logic [7:0] rsp_flags;
    logic       rsp_ready;

    modport slave (
        input  req0_valid, req1_valid, req0_inst, req1_inst,
        input  req0_ra, req0_rb, req1_ra, req1_rb,
        output req0_ready, req1_ready,
        output alu_inst, alu_ra, alu_rb,
        input  alu_rd, alu_flags,
        output rsp_valid, rsp_id, rsp_rd, rsp_flags,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req1_valid, req0_inst, req1_inst,
        output req0_ra, req0_rb, req1_ra, req1_rb,
        input  req0_ready, req1_ready,
        input  alu_inst, alu_ra, alu_rb,
        output alu_rd, alu_flags,
        input  rsp_valid, rsp_id, rsp_rd, rsp_flags,
        output rsp_ready
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight at a time: accept, execute for one cycle, hold response until taken.
module alu_share_ctrl (
    input logic              clk,
    input logic              rst_n,
    alu_share_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e     state_q, state_d;
    logic       last_grant_q;
    logic       grant_id;
    logic       accept;
    logic [7:0] inst_q, ra_q, rb_q;
    logic       id_q;
    logic [7:0] rd_q, flags_q;

    logic       ready0, ready1, rsp_valid;
    logic [7:0] alu_inst, alu_ra, alu_rb;

    // Contention goes to the requester that did not win last time.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = bus.req1_valid;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        ready0    = 1'b0;
        ready1    = 1'b0;
        rsp_valid = 1'b0;
        alu_inst  = 8'h00;
        alu_ra    = 8'h00;
        alu_rb    = 8'h00;
        unique case (state_q)
            StIdle: begin
                // Ready is combinational, so it must also be masked while reset is held.
                if (rst_n && (bus.req0_valid || bus.req1_valid)) begin
                    accept  = 1'b1;
                    ready0  = ~grant_id;
                    ready1  = grant_id;
                    state_d = StExec;
                end
            end
            StExec: begin
                alu_inst = inst_q;
                alu_ra   = ra_q;
                alu_rb   = rb_q;
                state_d  = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            inst_q       <= 8'h00;
            ra_q         <= 8'h00;
            rb_q         <= 8'h00;
            id_q         <= 1'b0;
            rd_q         <= 8'h00;
            flags_q      <= 8'h00;
        end else begin
            state_q <= state_d;
            if (accept) begin
                last_grant_q <= grant_id;
                id_q         <= grant_id;
                inst_q       <= grant_id ? bus.req1_inst : bus.req0_inst;
                ra_q         <= grant_id ? bus.req1_ra   : bus.req0_ra;
                rb_q         <= grant_id ? bus.req1_rb   : bus.req0_rb;
            end
            if (state_q == StExec) begin
                rd_q    <= bus.alu_rd;
                flags_q <= bus.alu_flags;
            end
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.alu_inst   = alu_inst;
    assign bus.alu_ra     = alu_ra;
    assign bus.alu_rb     = alu_rb;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_rd     = rd_q;
    assign bus.rsp_flags  = flags_q;

endmodule
